// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch encodings, kinds and counter reset value
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      BR_EQ,
      BR_NE,
      BR_LT,
      BR_GE,
      BR_LTU,
      BR_GEU,
      BR_NONE
   } branch_kind_e;

   // Weakly not-taken: the value just below the counter midpoint.
   function automatic int unsigned weak_not_taken(input int unsigned ctr_bits);
      return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational RV32I conditional branch comparator
module branch_compare
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            taken,
   output logic            legal
);

   branch_kind_e kind;
   logic         eq;
   logic         lt_s;
   logic         lt_u;

   assign eq   = (rs1_data == rs2_data);
   assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
   assign lt_u = (rs1_data < rs2_data);

   // Decode funct3 into a branch kind; 010/011 are reserved.
   always_comb begin
      kind = BR_NONE;
      case (funct3)
         F3_BEQ:  kind = BR_EQ;
         F3_BNE:  kind = BR_NE;
         F3_BLT:  kind = BR_LT;
         F3_BGE:  kind = BR_GE;
         F3_BLTU: kind = BR_LTU;
         F3_BGEU: kind = BR_GEU;
         default: kind = BR_NONE;
      endcase
   end

   // Select the condition for the decoded kind.
   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      case (kind)
         BR_EQ:   taken = eq;
         BR_NE:   taken = !eq;
         BR_LT:   taken = lt_s;
         BR_GE:   taken = !lt_s;
         BR_LTU:  taken = lt_u;
         BR_GEU:  taken = !lt_u;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - branch resolve, BHT predict/train and statistics
module branch_resolve_bht
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int CTR_BITS    = 2,
   parameter int STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   fetch_pc,
   output logic              pred_taken,
   input  logic              ex_valid,
   input  logic              branch_ctrl,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic              ex_pred_taken,
   output logic              pc_sel,
   output logic              mispredict,
   output logic              illegal_branch,
   output logic [STAT_W-1:0] branch_count,
   output logic [STAT_W-1:0] mispredict_count
);

   localparam int                  IDX_W    = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_not_taken(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [STAT_W-1:0]   STAT_MAX = '1;

   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
   logic [IDX_W-1:0]    fetch_idx;
   logic [IDX_W-1:0]    upd_idx;
   logic                res;
   logic                cond_taken;
   logic                cond_legal;
   logic                train;
   logic [CTR_BITS-1:0] ctr_cur;
   logic [CTR_BITS-1:0] ctr_next;
   logic                unused_pc_bits;

   // Word-aligned PCs: bits [1:0] never select an entry, high bits alias.
   assign fetch_idx      = fetch_pc[IDX_W+1:2];
   assign upd_idx        = ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                             ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

   branch_compare #(
      .XLEN (XLEN)
   ) u_compare (
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .taken    (cond_taken),
      .legal    (cond_legal)
   );

   assign res            = ex_valid & branch_ctrl;
   assign train          = res & cond_legal;
   assign pc_sel         = train & cond_taken;
   assign mispredict     = train & (pc_sel != ex_pred_taken);
   assign illegal_branch = res & !cond_legal;

   // Asynchronous read: a same-cycle update becomes visible next cycle.
   assign pred_taken = bht[fetch_idx][CTR_BITS-1];

   // Saturating step of the entry being trained.
   always_comb begin
      ctr_cur  = bht[upd_idx];
      ctr_next = ctr_cur;
      if (pc_sel) begin
         if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
      end else begin
         if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
      end
   end

   // Table: reset every entry to weakly not-taken, train on legal branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
      end else if (train) begin
         bht[upd_idx] <= ctr_next;
      end
   end

   // Statistics: saturating counts of resolved branches and mispredictions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (train) begin
         if (branch_count != STAT_MAX) branch_count <= branch_count + 1'b1;
         if (mispredict && (mispredict_count != STAT_MAX))
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
Parametrised branch unit for the single-cycle/sequential RV32I core. It resolves all six RV32I conditional branches by comparing operands directly. It also holds a direct-mapped table of saturating counters (the BHT) that predicts taken/not-taken at fetch and trains on every resolved branch. It raises a mispredict flag, keeps branch and mispredict statistics counters, and sits between the register-file read ports / main control and the PC mux / fetch stage.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 16, table depth; power of two, >= 2
CTR_BITS, 2, width of each saturating counter; >= 1
STAT_W, 16, width of each statistics counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous, active-low reset
fetch_pc  in  XLEN  PC of instruction being fetched
pred_taken  out  1  prediction for fetch_pc: MSB of its table entry
ex_valid  in  1  a valid instruction is in execute this cycle
branch_ctrl  in  1  main control marks a conditional branch
funct3  in  3  instruction[14:12]
rs1_data  in  XLEN  first operand
rs2_data  in  XLEN  second operand
ex_pc  in  XLEN  PC of the executing branch
ex_pred_taken  in  1  prediction carried down from fetch for this branch
pc_sel  out  1  actual outcome: take branch target
mispredict  out  1  resolved outcome differs from ex_pred_taken
illegal_branch  out  1  branch with reserved funct3
branch_count  out  STAT_W  resolved legal branches since reset
mispredict_count  out  STAT_W  mispredictions since reset

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Definitions:
  - IDX_W = log2(BHT_ENTRIES).
  - Fetch index = fetch_pc[IDX_W+1:2].
  - Update index = ex_pc[IDX_W+1:2].
- Resolve (combinational, zero latency). `res` = ex_valid & branch_ctrl.
  - funct3 000 BEQ: taken when rs1 == rs2.
  - 001 BNE: taken when rs1 != rs2.
  - 100 BLT: signed rs1 < rs2.
  - 101 BGE: signed rs1 >= rs2.
  - 110 BLTU: unsigned rs1 < rs2.
  - 111 BGEU: unsigned rs1 >= rs2.
  - 010/011: reserved. illegal_branch = res, pc_sel = 0.
  - pc_sel = res & legal & condition. It is 0 whenever res = 0.
  - mispredict = res & legal & (pc_sel != ex_pred_taken).
- Predict (combinational): pred_taken = table[fetch index][CTR_BITS-1]. It is asynchronous-read.
- Train (sequential, on the rising edge when res & legal):
  - taken: table[update index] += 1, saturating at 2^CTR_BITS-1.
  - not taken: table[update index] -= 1, saturating at 0.
  - No write on illegal or non-branch cycles.
- Statistics (sequential, on the same condition as training):
  - branch_count += 1.
  - mispredict_count += 1 when mispredict.
  - Both saturate at all-ones and do not wrap.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - Every table entry = 2^(CTR_BITS-1)-1, i.e. weakly not-taken (01 for 2 bits).
  - branch_count = mispredict_count = 0.
  - Outputs after reset: pred_taken = 0. pc_sel, mispredict and illegal_branch follow inputs, and are 0 while ex_valid = 0.
  - Reset asserted mid-update discards the update; no partial state survives.
- Same-index read/write in one cycle: pred_taken shows the pre-update value. The new value is visible from the next cycle.
- Aliasing: PCs differing only above bit IDX_W+1 share an entry. This is by design.
- Operand edge cases:
  - Signed compares treat bit XLEN-1 as sign. 0x8000_0000 < 0x7FFF_FFFF is signed-true and unsigned-false.
  - Equal operands: BGE/BGEU taken, BLT/BLTU not taken.

Decomposition:
- Shared package `branch_pkg`:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Enum of branch kinds.
  - Function returning the weakly-not-taken reset value for CTR_BITS.
- One natural sub-module: `branch_compare`. Purely combinational; inputs funct3 and operands, outputs taken and legal. It is reused by a future pipelined execute stage.
- Table, training and statistics stay in the top.

Test Plan:
1. Reset, then fetch_pc = 0x0000_0040 with no branches -> pred_taken = 0, branch_count = 0.
2. BLT with rs1 = 0xFFFF_FFFF, rs2 = 1 -> pc_sel = 1. The same operands with BLTU -> pc_sel = 0. BGE and BGEU with rs1 = rs2 = 5 -> pc_sel = 1.
3. Branch at ex_pc = 0x100, taken three consecutive times with ex_pred_taken = 0:
   - cycle 1 -> mispredict = 1 (and on every cycle ex_pred_taken = 0 mismatches the taken outcome);
   - entry steps 01 -> 10 -> 11 -> 11 (saturates);
   - pred_taken for fetch_pc = 0x100 is 1 from the cycle after the first update;
   - mispredict_count = 3.
4. Same-cycle case: fetch_pc = ex_pc = 0x100, entry = 01, taken -> pred_taken = 0 that cycle, 1 the next.
5. funct3 = 010 with branch_ctrl = 1 -> illegal_branch = 1, pc_sel = 0, no table or counter change. With ex_valid = 0 and any funct3 -> all flags 0.
6. Statistics and reset:
   - STAT_W = 4, 20 legal branches -> branch_count saturates at 15.
   - rst_n pulsed low mid-cycle -> counters 0 and entries 01 immediately, without waiting for a clock edge.
